// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: pipelined ALU functional unit with saturating add/sub, min/max, carry flag,
// opaque tag and an elastic valid/ready pipeline of STAGES registers with flush.
module fu_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] port_output,
    output logic [TAG_W-1:0] out_tag,
    output logic             overflow,
    output logic             carry,
    output logic             negative,
    output logic             zero
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

    logic [SH_W-1:0]  shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ov;
    logic             sub_ov;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] sat;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;
    logic             alu_cy;

    assign shamt  = port_b[SH_W-1:0];
    assign sum    = {1'b0, port_a} + {1'b0, port_b};
    assign diff   = {1'b0, port_a} + {1'b0, ~port_b} + (WIDTH+1)'(1);
    assign add_ov = (port_a[WIDTH-1] == port_b[WIDTH-1]) && (sum[WIDTH-1] != port_a[WIDTH-1]);
    assign sub_ov = (port_a[WIDTH-1] != port_b[WIDTH-1]) && (diff[WIDTH-1] != port_a[WIDTH-1]);
    assign lt_s   = $signed(port_a) < $signed(port_b);
    assign lt_u   = port_a < port_b;
    // Overflow direction always follows the sign of A for both add and sub.
    assign sat    = port_a[WIDTH-1] ? MIN_S : MAX_S;

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        alu_cy  = 1'b0;
        case (aluop)
            4'd0:  alu_res = port_a << shamt;
            4'd1:  alu_res = port_a >> shamt;
            4'd2:  alu_res = $signed(port_a) >>> shamt;
            4'd3:  begin alu_res = sum[WIDTH-1:0]; alu_ov = add_ov; alu_cy = sum[WIDTH]; end
            4'd4:  begin alu_res = diff[WIDTH-1:0]; alu_ov = sub_ov; alu_cy = diff[WIDTH]; end
            4'd5:  alu_res = port_a & port_b;
            4'd6:  alu_res = port_a | port_b;
            4'd7:  alu_res = port_a ^ port_b;
            4'd8:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            4'd9:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            4'd10: begin alu_res = add_ov ? sat : sum[WIDTH-1:0]; alu_ov = add_ov; alu_cy = sum[WIDTH]; end
            4'd11: begin alu_res = sub_ov ? sat : diff[WIDTH-1:0]; alu_ov = sub_ov; alu_cy = diff[WIDTH]; end
            4'd12: alu_res = lt_s ? port_a : port_b;
            4'd13: alu_res = lt_s ? port_b : port_a;
            4'd14: alu_res = lt_u ? port_a : port_b;
            4'd15: alu_res = lt_u ? port_b : port_a;
        endcase
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] ov_q, ov_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];

    // A stage may load when empty or when its content moves on this cycle.
    always_comb begin
        load = '0;
        load[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) load[k] = !valid_q[k] || load[k+1];
    end

    always_comb begin
        valid_d = '0;
        ov_d = '0;
        cy_d = '0;
        valid_d[0] = in_valid;
        ov_d[0] = alu_ov;
        cy_d[0] = alu_cy;
        res_d[0] = alu_res;
        tag_d[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            ov_d[k] = ov_q[k-1];
            cy_d[k] = cy_q[k-1];
            res_d[k] = res_q[k-1];
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            ov_q <= '0;
            cy_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush) valid_q[k] <= 1'b0;
                else if (load[k]) valid_q[k] <= valid_d[k];
                if (load[k]) begin
                    ov_q[k] <= ov_d[k];
                    cy_q[k] <= cy_d[k];
                    res_q[k] <= res_d[k];
                    tag_q[k] <= tag_d[k];
                end
            end
        end
    end

    assign in_ready    = load[0];
    assign out_valid   = valid_q[STAGES-1];
    assign port_output = res_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];
    assign overflow    = ov_q[STAGES-1];
    assign carry       = cy_q[STAGES-1];
    assign negative    = port_output[WIDTH-1];
    assign zero        = port_output == '0;
endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb_fu_alu_pipe: randomized and directed bench for fu_alu_pipe against a queue-based
// behavioural model of the ALU and the elastic pipeline.
module tb_fu_alu_pipe;
    localparam int STAGES = 2;
    localparam longint MAXI = 2147483647;
    localparam longint MINI = -MAXI - 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluop;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [5:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] port_output;
    logic [5:0]  out_tag;
    logic        overflow;
    logic        carry;
    logic        negative;
    logic        zero;

    fu_alu_pipe #(.WIDTH(32), .STAGES(STAGES), .TAG_W(6)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .port_a(port_a), .port_b(port_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .port_output(port_output),
        .out_tag(out_tag), .overflow(overflow), .carry(carry), .negative(negative), .zero(zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        cy;
        logic [5:0]  tag;
        int          acc;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;
    int popped = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {overflow, carry, result} from plain signed/unsigned 64-bit arithmetic.
    function automatic logic [33:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, s;
        logic [31:0] r;
        logic ov, cy;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = int'(b[4:0]);
        s = 0;
        r = 0;
        ov = 0;
        cy = 0;
        case (op)
            4'd0: r = a << sh;
            4'd1: r = a >> sh;
            4'd2: begin s = sa >>> sh; r = s[31:0]; end
            4'd3, 4'd10: begin
                s = sa + sb;
                ov = s > MAXI || s < MINI;
                cy = (ua + ub) > 64'hFFFFFFFF;
                r = s[31:0];
                if (op == 4'd10) r = s > MAXI ? 32'h7FFFFFFF : (s < MINI ? 32'h80000000 : s[31:0]);
            end
            4'd4, 4'd11: begin
                s = sa - sb;
                ov = s > MAXI || s < MINI;
                cy = ua >= ub;
                r = s[31:0];
                if (op == 4'd11) r = s > MAXI ? 32'h7FFFFFFF : (s < MINI ? 32'h80000000 : s[31:0]);
            end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (ua < ub) ? 32'd1 : 32'd0;
            4'd12: r = (sa < sb) ? a : b;
            4'd13: r = (sa > sb) ? a : b;
            4'd14: r = (ua < ub) ? a : b;
            4'd15: r = (ua > ub) ? a : b;
        endcase
        return {ov, cy, r};
    endfunction

    // Compare process: every cycle, outputs against the model queue.
    always @(negedge CLK) begin
        item_t it;
        logic [33:0] m;
        logic exp_v;
        if (RST) begin
            q.delete();
        end else begin
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (q[0].acc + STAGES) <= cyc;
            chk("out_valid", out_valid, exp_v);
            chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
            if (out_valid && exp_v) begin
                chk("result", port_output, q[0].res);
                chk("out_tag", out_tag, q[0].tag);
                chk("overflow", overflow, q[0].ov);
                chk("carry", carry, q[0].cy);
                chk("negative", negative, q[0].res[31]);
                chk("zero", zero, q[0].res == 32'd0);
                if (out_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) begin
                m = ref_alu(aluop, port_a, port_b);
                it.res = m[31:0];
                it.cy = m[32];
                it.ov = m[33];
                it.tag = in_tag;
                it.acc = cyc;
                q.push_back(it);
            end
        end
        cyc++;
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, output int waits);
        bit acc;
        in_valid = 1'b1;
        aluop = op;
        port_a = a;
        port_b = b;
        in_tag = t;
        waits = 0;
        acc = 0;
        while (!acc && waits < 50) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK);
            #1;
            if (!acc) waits++;
        end
        if (!acc) chk("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return $urandom % 40;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w, tot, p0;
        RST = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        aluop = 4'd0;
        port_a = 32'd0;
        port_b = 32'd0;
        in_tag = 6'd0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_port_output", port_output, 0);
        chk("rst_zero", zero, 1);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_flags", {overflow, carry, negative}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        chk("ref_add", ref_alu(4'd3, 32'h7FFFFFFF, 32'd1), {2'b10, 32'h80000000});
        chk("ref_adds", ref_alu(4'd10, 32'h7FFFFFFF, 32'd1), {2'b10, 32'h7FFFFFFF});
        chk("ref_subs", ref_alu(4'd11, 32'h80000000, 32'd1), {2'b11, 32'h80000000});
        chk("ref_sub", ref_alu(4'd4, 32'd5, 32'd5), {2'b01, 32'h0});
        chk("ref_min", ref_alu(4'd12, 32'hFFFFFFFF, 32'd1), {2'b00, 32'hFFFFFFFF});
        chk("ref_minu", ref_alu(4'd14, 32'hFFFFFFFF, 32'd1), {2'b00, 32'h1});
        chk("ref_sra", ref_alu(4'd2, 32'h80000000, 32'h21), {2'b00, 32'hC0000000});
        chk("ref_sltu", ref_alu(4'd9, 32'd1, 32'hFFFFFFFF), {2'b00, 32'h1});

        send(4'd3, 32'h7FFFFFFF, 32'd1, 6'd5, w);
        @(negedge CLK);
        chk("lat_early", out_valid, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("lat_valid", out_valid, 1);
        chk("lat_result", port_output, 32'h80000000);
        chk("lat_flags", {overflow, carry, negative}, 3'b101);
        chk("lat_tag", out_tag, 5);
        @(posedge CLK);
        #1;
        send(4'd10, 32'h7FFFFFFF, 32'd1, 6'd6, w);
        send(4'd11, 32'h80000000, 32'd1, 6'd7, w);
        send(4'd4, 32'd5, 32'd5, 6'd8, w);
        send(4'd12, 32'hFFFFFFFF, 32'd1, 6'd9, w);
        send(4'd14, 32'hFFFFFFFF, 32'd1, 6'd10, w);
        send(4'd2, 32'h80000000, 32'h21, 6'd11, w);
        send(4'd9, 32'd1, 32'hFFFFFFFF, 6'd12, w);
        idle(5);

        out_ready = 1'b0;
        p0 = popped;
        send(4'd3, 32'd10, 32'd1, 6'd1, w);
        send(4'd3, 32'd20, 32'd2, 6'd2, w);
        fork
            begin
                send(4'd3, 32'd30, 32'd3, 6'd3, w);
                send(4'd3, 32'd40, 32'd4, 6'd4, w);
            end
            begin
                repeat (3) begin
                    @(negedge CLK);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold_tag", out_tag, 1);
                    chk("bp_hold_res", port_output, 32'd11);
                end
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("bp_pops", popped - p0, 4);

        tot = 0;
        p0 = popped;
        for (int i = 0; i < 16; i++) begin
            send(4'($urandom), rnd(), rnd(), 6'(16 + i), w);
            tot += w;
        end
        idle(4);
        chk("thru_stalls", tot, 0);
        chk("thru_pops", popped - p0, 16);

        out_ready = 1'b0;
        send(4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 6'd40, w);
        send(4'd6, 32'h1, 32'h2, 6'd41, w);
        in_valid = 1'b1;
        in_tag = 6'd42;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("flush_out_valid", out_valid, 0);
        p0 = popped;
        out_ready = 1'b1;
        idle(5);
        chk("flush_pops", popped - p0, 0);

        send(4'd3, 32'd1, 32'd1, 6'd50, w);
        send(4'd7, 32'hFFFF, 32'h1, 6'd51, w);
        send(4'd3, 32'd7, 32'd9, 6'd52, w);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_port_output", port_output, 0);
        chk("arst_zero", zero, 1);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        repeat (3000) begin
            in_valid = ($urandom % 4) != 0;
            aluop = 4'($urandom);
            port_a = rnd();
            port_b = rnd();
            in_tag = 6'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 40) == 0;
            @(posedge CLK);
            #1;
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle(8);
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
